stage_4_sync_sink: RTL and testbench
====================================

Name: stage_4_sync_sink

Overview:
- Receiving stage directly downstream of stage_4.
- Consumes stage_4's two-phase bundled-data output: valid_out toggles per token, data_out is 3 bits.
- Synchronises each token into the clk domain, buffers it in a small FIFO and returns a two-phase ack toggle to stage_4's ack_in.
- Presents tokens to synchronous logic on a valid/ready interface.

Parameters:
- DATA_W, 3, width of token data; matches stage_4 data_out.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in the valid_in synchroniser; at least 2.

Ports:
- clk  input  1  single clock for the block.
- rst  input  1  asynchronous, active-high reset.
- valid_in  input  1  two-phase request from stage_4 valid_out; each level change is one token.
- data_in  input  DATA_W  bundled data from stage_4 data_out; stable from before the valid_in toggle until the matching ack_out toggle.
- ack_out  output  1  two-phase acknowledge to stage_4 ack_in; toggles once per accepted token.
- m_valid  output  1  FIFO holds at least one token.
- m_ready  input  1  consumer accepts the head token when m_valid and m_ready are both high at a clk edge.
- m_data  output  DATA_W  head-of-FIFO token.
- count  output  log2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values, applied immediately on rst and held while rst is high:
  - all synchroniser flops 0; phase register ph 0; ack_out 0.
  - count 0, m_valid 0, m_data 0, FIFO pointers 0.
- Reset mid-operation discards buffered tokens and any pending event.
- Upstream is reset alongside this block; after reset both phases are 0.
- Synchroniser: valid_in passes through SYNC_STAGES flops to give vs. data_in is not synchronised; the bundled-data timing plus synchroniser delay guarantees it is settled.
- Event detect: pending = (vs != ph).
- Accept condition: pending and (count < DEPTH, or a pop happens at the same edge).
- On accept, at one clk edge:
  - write data_in at the write pointer; advance the write pointer (wraps modulo DEPTH).
  - ph <= vs.
  - ack_out <= vs, so ack_out always equals ph.
- Pending but full with no pop: hold. No write, no ack toggle, ph unchanged. The token stays on data_in because stage_4 is stalled waiting for the ack.
- Pop: m_valid and m_ready at an edge advances the read pointer (wraps modulo DEPTH).
- count update per edge: +1 on write only, -1 on pop only, unchanged on simultaneous write and pop.
- Full with pending token and pop at the same edge: accept proceeds; count stays DEPTH.
- Empty: m_valid is 0; m_ready is ignored and never underflows.
- m_valid = (count != 0). m_data = fifo[rd_ptr], driven combinationally from registered storage.
- Latency, valid_in toggle to m_valid high with FIFO not full:
  - toggle sampled at edge 1; vs changes at edge SYNC_STAGES.
  - write and ack toggle at edge SYNC_STAGES+1.
  - m_valid high after that edge: 3 edges for the default.
- Throughput: at most one token per handshake round trip. A valid_in toggle arriving before ack_out toggles is a protocol violation; behaviour is undefined and not checked.
- Order: tokens leave in acceptance order, no loss, no duplication.

Test Plan:
- Reset then single token: rst high 10 ns then low; data_in=1, valid_in 0->1; m_ready=0.
  - Expect ack_out 0->1 at the 3rd clk edge after the toggle.
  - Expect m_valid=1, m_data=1, count=1.
- Stream with free consumer:
  - Bench emulates stage_4: ack_out change -> after 5 ns increment data_in (wrapping 7->0) and toggle valid_in. m_ready=1.
  - Expect m_data sequence 1,2,...,7,0,1 with no gaps or repeats; count never exceeds 1.
- Full stall: m_ready=0, send tokens 1..5.
  - Expect count=4 and ack_out toggled exactly 4 times.
  - Expect 5th token pending with ack_out constant; then m_ready=1 for one cycle: pop 1 and accept 5 in the same edge, count stays 4, ack_out toggles.
- Drain and wrap: from the full state, m_ready=1 continuously.
  - Expect m_data 2,3,4,5, then m_valid=0, count=0.
  - Pointers wrap; a following token 6 is output correctly.
- Reset mid-operation: assert rst asynchronously with count=3 and a token pending.
  - Expect count, m_valid and ack_out to go 0 immediately, before the next clk edge.
  - After release, a fresh valid_in 0->1 token is accepted normally.

Source files
------------

// File: rtl/stage_4_sync_sink.sv
// ============================================================================
// Module   : stage_4_sync_sink
// Purpose  : Two-phase bundled-data receiver that buffers stage_4 tokens in a
//            small FIFO and presents them on a valid/ready interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_4_sync_sink #(
    parameter int DATA_W      = 3,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   ph_q, ph_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [DATA_W-1:0]      fifo_q [DEPTH];
    logic [DATA_W-1:0]      fifo_d [DEPTH];

    logic vs, pending, pop, accept;

    assign vs      = sync_q[SYNC_STAGES-1];
    assign pending = (vs != ph_q);
    assign pop     = (count_q != '0) && m_ready;
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign accept  = pending && ((count_q < C_DEPTH) || pop);

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], valid_in};
        ph_d     = ph_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            fifo_d[i] = fifo_q[i];
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = data_in;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            ph_d             = vs;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q   <= '0;
            ph_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            sync_q   <= sync_d;
            ph_q     <= ph_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    // The acknowledge is the accepted phase itself, so it never diverges from ph.
    assign ack_out = ph_q;
    assign m_valid = (count_q != '0);
    assign m_data  = fifo_q[rd_ptr_q];
    assign count   = count_q;

endmodule

`default_nettype wire

// File: tb/tb_stage_4_sync_sink.sv
// ============================================================================
// Module   : tb_stage_4_sync_sink
// Purpose  : Directed self-checking bench for stage_4_sync_sink.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_4_sync_sink;

    logic       clk;
    logic       rst;
    logic       valid_in;
    logic [2:0] data_in;
    logic       ack_out;
    logic       m_valid;
    logic       m_ready;
    logic [2:0] m_data;
    logic [2:0] count;

    int checks;
    int errors;
    int pop_cnt;
    logic       mon_en;
    logic [2:0] exp_next;

    stage_4_sync_sink #(
        .DATA_W      (3),
        .DEPTH       (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .valid_in (valid_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Stage_4 emulation: present a token, toggle the request, wait for the ack.
    task automatic send_token(input string tag, input logic [2:0] d);
        logic prev;
        logic exp_ack;
        prev    = ack_out;
        exp_ack = ~prev;
        @(negedge clk);
        data_in  = d;
        valid_in = ~valid_in;
        for (int k = 0; k < 20 && ack_out == prev; k++) begin
            @(posedge clk);
            #1;
        end
        check(tag, {31'b0, ack_out}, {31'b0, exp_ack});
    endtask

    // Records every pop during the streaming phase.
    always @(negedge clk) begin
        if (mon_en) begin
            check("stream_count_le1", {31'b0, (count <= 3'd1)}, 32'd1);
            if (m_valid && m_ready) begin
                check("stream_data", {29'b0, m_data}, {29'b0, exp_next});
                exp_next = exp_next + 3'd1;
                pop_cnt++;
            end
        end
    end

    initial begin
        logic prev;
        logic exp_ack;
        checks   = 0;
        errors   = 0;
        pop_cnt  = 0;
        mon_en   = 1'b0;
        exp_next = 3'd1;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 3'd0;
        m_ready  = 1'b0;

        // Reset and single token
        #10;
        check("rst_count",   {29'b0, count},   32'd0);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_ack",     {31'b0, ack_out}, 32'd0);
        check("rst_m_data",  {29'b0, m_data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        data_in  = 3'd1;
        valid_in = 1'b1;
        @(posedge clk); #1;
        check("lat_edge1_ack", {31'b0, ack_out}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge2_ack", {31'b0, ack_out}, 32'd0);
        @(posedge clk); #1;
        check("lat_edge3_ack", {31'b0, ack_out}, 32'd1);
        check("single_m_valid", {31'b0, m_valid}, 32'd1);
        check("single_m_data",  {29'b0, m_data},  32'd1);
        check("single_count",   {29'b0, count},   32'd1);

        // Stream with a free consumer: expect 1,2,...,7,0,1
        @(posedge clk); #1;
        m_ready = 1'b1;
        mon_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_token("stream_ack", 3'(data_in + 3'd1));
        end
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        m_ready = 1'b0;
        check("stream_pops",  pop_cnt, 32'd9);
        check("stream_count", {29'b0, count}, 32'd0);

        // Full stall: four tokens fill the FIFO, the fifth waits
        for (int i = 1; i <= 4; i++) begin
            send_token("stall_ack", 3'(i));
        end
        check("full_count", {29'b0, count}, 32'd4);
        prev = ack_out;
        @(negedge clk);
        data_in  = 3'd5;
        valid_in = ~valid_in;
        repeat (8) @(posedge clk);
        #1;
        check("full_ack_hold",   {31'b0, ack_out}, {31'b0, prev});
        check("full_count_hold", {29'b0, count},   32'd4);
        check("full_head",       {29'b0, m_data},  32'd1);
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        exp_ack = ~prev;
        check("popfull_ack",   {31'b0, ack_out}, {31'b0, exp_ack});
        check("popfull_count", {29'b0, count},   32'd4);
        check("popfull_head",  {29'b0, m_data},  32'd2);

        // Drain and wrap
        m_ready = 1'b1;
        for (int e = 2; e <= 5; e++) begin
            check("drain_data", {29'b0, m_data}, 32'(e));
            @(posedge clk); #1;
        end
        check("drain_m_valid", {31'b0, m_valid}, 32'd0);
        check("drain_count",   {29'b0, count},   32'd0);
        @(posedge clk); #1;
        check("empty_no_underflow", {29'b0, count}, 32'd0);
        send_token("wrap_ack", 3'd6);
        check("wrap_m_valid", {31'b0, m_valid}, 32'd1);
        check("wrap_m_data",  {29'b0, m_data},  32'd6);
        @(posedge clk); #1;
        m_ready = 1'b0;
        check("wrap_drained", {29'b0, count}, 32'd0);

        // Reset mid-operation with three buffered tokens and one pending
        for (int i = 1; i <= 3; i++) begin
            send_token("pre_rst_ack", 3'(i));
        end
        @(negedge clk);
        data_in  = 3'd4;
        valid_in = ~valid_in;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_count", {29'b0, count}, 32'd3);
        #1;
        rst      = 1'b1;
        valid_in = 1'b0;
        data_in  = 3'd0;
        #1;
        check("async_rst_count",   {29'b0, count},   32'd0);
        check("async_rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("async_rst_ack",     {31'b0, ack_out}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_token("post_rst_ack", 3'd5);
        check("post_rst_m_data", {29'b0, m_data}, 32'd5);
        check("post_rst_count",  {29'b0, count},  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
